// File: rtl/riscv_vrf_pkg.sv
// Shared defaults and clear-engine state type for the banked vector register file.
package riscv_vrf_pkg;
  localparam int NREGS_DEF = 32;
  localparam int VLMAX_DEF = 64;
  localparam int LANES_DEF = 4;
  localparam int DW_DEF    = 32;

  typedef enum logic {IDLE, CLEAR} clr_state_e;

  // Number of LANES-wide groups that make up one vector.
  function automatic int num_groups(input int vlmax, input int lanes);
    return vlmax / lanes;
  endfunction

  // Counter width for a group index, never zero.
  function automatic int grp_width(input int vlmax, input int lanes);
    return (vlmax / lanes > 1) ? $clog2(vlmax / lanes) : 1;
  endfunction
endpackage

// File: rtl/riscv_vrf_clear_fsm.sv
// Clear engine: walks one latched register group by group, one group per cycle.
module riscv_vrf_clear_fsm
  import riscv_vrf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int VLMAX = VLMAX_DEF,
  parameter int LANES = LANES_DEF,
  localparam int AW   = $clog2(NREGS),
  localparam int GW   = grp_width(VLMAX, LANES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  input  logic [AW-1:0] clr_addr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_addr,
  output logic [GW-1:0] cur_grp
);
  localparam int NGRP = num_groups(VLMAX, LANES);

  clr_state_e    state, state_nx;
  logic [GW-1:0] grp;
  logic [AW-1:0] addr_q;
  logic          done_q;
  logic          last;

  assign last = (grp == GW'(NGRP - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clr_req) state_nx = CLEAR;
      CLEAR:   if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      grp    <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state == CLEAR) && last;
      if (state == IDLE && clr_req) begin
        addr_q <= clr_addr;
        grp    <= '0;
      end else if (state == CLEAR) begin
        grp <= grp + 1'b1;  // wraps to 0 after the last group
      end
    end
  end

  assign busy     = (state == CLEAR);
  assign done     = done_q;
  assign cur_addr = addr_q;
  assign cur_grp  = grp;
endmodule

// File: rtl/riscv_core_dpath_vector_regfile_banked.sv
// Vector register file: two combinational read ports, one lane-masked write port,
// vl tail masking, and a multi-cycle whole-register clear.
module riscv_core_dpath_vector_regfile_banked
  import riscv_vrf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int VLMAX = VLMAX_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  localparam int AW   = $clog2(NREGS),
  localparam int IW   = $clog2(VLMAX)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IW:0]         vl,
  input  logic [AW-1:0]       raddr0,
  input  logic [IW-1:0]       ridx0,
  output logic [LANES*DW-1:0] rdata0,
  input  logic [AW-1:0]       raddr1,
  input  logic [IW-1:0]       ridx1,
  output logic [LANES*DW-1:0] rdata1,
  input  logic [LANES-1:0]    wen,
  input  logic [AW-1:0]       waddr,
  input  logic [IW-1:0]       widx,
  input  logic [LANES*DW-1:0] wdata,
  output logic                wr_rdy,
  input  logic                clr_req,
  input  logic [AW-1:0]       clr_addr,
  output logic                clr_busy,
  output logic                clr_done
);
  localparam int GW = grp_width(VLMAX, LANES);

  logic [DW-1:0] mem [NREGS*VLMAX];

  logic          busy, done;
  logic [AW-1:0] cur_addr;
  logic [GW-1:0] cur_grp;
  logic          wr_drop;

  logic [LANES-1:0][IW-1:0] ridx0_l, ridx1_l, widx_l, cidx_l;
  logic [LANES-1:0]         rok0, rok1, wok;
  logic [LANES-1:0][DW-1:0] rd0, rd1, wd;
  logic                     hide0, hide1;

  riscv_vrf_clear_fsm #(.NREGS(NREGS), .VLMAX(VLMAX), .LANES(LANES)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_addr (clr_addr),
    .busy     (busy),
    .done     (done),
    .cur_addr (cur_addr),
    .cur_grp  (cur_grp)
  );

  // The register under clear reads as zero for the whole clear, not just cleared groups.
  assign hide0 = busy && (raddr0 == cur_addr);
  assign hide1 = busy && (raddr1 == cur_addr);
  assign wd    = wdata;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign ridx0_l[k] = ridx0 + IW'(k);
    assign ridx1_l[k] = ridx1 + IW'(k);
    assign widx_l[k]  = widx + IW'(k);
    assign cidx_l[k]  = IW'(IW'(cur_grp) * IW'(LANES)) + IW'(k);

    assign rok0[k] = ({1'b0, ridx0_l[k]} < vl) && !hide0;
    assign rok1[k] = ({1'b0, ridx1_l[k]} < vl) && !hide1;
    assign wok[k]  = wen[k] && !busy && ({1'b0, widx_l[k]} < vl);

    assign rd0[k] = rok0[k] ? mem[{raddr0, ridx0_l[k]}] : '0;
    assign rd1[k] = rok1[k] ? mem[{raddr1, ridx1_l[k]}] : '0;
  end

  assign rdata0 = rd0;
  assign rdata1 = rd1;

  // Clear writes are held off on a reset edge so a reset mid-clear stops at the current group.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (busy && !reset)
        mem[{cur_addr, cidx_l[k]}] <= '0;
      else if (wok[k])
        mem[{waddr, widx_l[k]}] <= wd[k];
    end
  end

  assign wr_drop = busy && |wen;

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!wr_drop) else $warning("write dropped while clear engine busy");
  end

  assign wr_rdy   = !busy;
  assign clr_busy = busy;
  assign clr_done = done;
endmodule
